mdu_sequencer: RTL
==================

// Module: mdu_sequencer
// PURPOSE
//  Multi-cycle multiply/divide unit (MDU) for the R-type mult/multu/div/divu instructions.
//  Owns the HI/LO registers and runs an iterative shift-add multiplier or restoring divider, one bit per cycle.
//  Sits beside the ALU in EX and drives a stall to the pipeline while a result is pending.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO width; iteration count per operation
// PORTS
//  clk           in   1      system clock, rising edge
//  reset         in   1      asynchronous, active-low reset
//  start         in   1      valid R-type instruction in EX (opcode 000000)
//  funct         in   6      funct field: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo
//  rs_val        in   WIDTH  multiplicand / dividend
//  rt_val        in   WIDTH  multiplier / divisor
//  flush         in   1      synchronous abort of the in-flight operation
//  busy          out  1      state is MUL, DIV or FIX
//  stall         out  1      combinational: hold the pipeline
//  done          out  1      one-cycle pulse; HI/LO final
//  div_by_zero   out  1      one-cycle pulse with done when divisor was 0
//  hi            out  WIDTH  HI register (product upper half / remainder)
//  lo            out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, hi=lo=0, cnt=0, done=0, div_by_zero=0, busy=0, internal datapath regs 0.
//  FSM states: IDLE, MUL, DIV, FIX, DONE.
//   IDLE/DONE: accept on start & funct in {mult,multu,div,divu} & !flush.
//     Latch |operands| (signed ops) or raw operands (unsigned ops); record the sign of the result and the dividend.
//     Set cnt=0 and go to MUL or DIV. Any other funct: no state change.
//   Div/divu with rt_val==0: go straight to DONE. hi/lo unchanged; div_by_zero=1 in the DONE cycle.
//   MUL: one shift-add step per edge, WIDTH steps (cnt 0..WIDTH-1), then FIX.
//   DIV: one restoring step per edge, WIDTH steps, then FIX.
//   FIX: product negated (2*WIDTH-bit two's complement) if the operand signs differ.
//     Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
//     Write {hi,lo} = product, or hi=remainder and lo=quotient. Go to DONE.
//   DONE: done=1 for exactly this cycle. Go to IDLE unless a new op is accepted (back-to-back allowed).
//  Latency: accept edge E0; hi/lo written at edge E(WIDTH+1); done high in the cycle after.
//    That is 34 cycles for WIDTH=32. Divide-by-zero: done in the cycle after E0.
//  busy = state in {MUL, DIV, FIX}.
//  stall = busy & start & funct in {mult, multu, div, divu, mfhi, mflo}. No stall in IDLE/DONE.
//  Arithmetic: all intermediate values are unsigned magnitudes (WIDTH+1-bit partial remainder, 2*WIDTH-bit product).
//    Signed div of -2^(W-1) / -1 wraps: lo=0x80000000, hi=0.
//  flush: in MUL/DIV/FIX go to IDLE at the next edge; hi/lo unchanged; no done pulse.
//    In IDLE/DONE, flush blocks acceptance of start. Flush has priority over start.
//  reset mid-operation: immediate return to reset values; the partial result is discarded.
//  hi/lo change only in FIX, or on reset.
// TESTING
//  1 mult rs=0xFFFFFFFD(-3) rt=7 -> done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1..33.
//  2 multu 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then a back-to-back divu issued in the DONE cycle is accepted.
//  3 div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 -> lo=3, hi=1. div 0x80000000/-1 -> lo=0x80000000, hi=0.
//  4 divu 5/0 with hi=0x11, lo=0x22 -> done=div_by_zero=1 in cycle 1; hi/lo stay 0x11/0x22; busy never asserted.
//  5 mult accepted, then start+mflo held -> stall=1 in every busy cycle, 0 in the DONE cycle.
//    flush at cycle 10 of a later op -> IDLE next cycle, no done, hi/lo unchanged.
//  6 reset pulled low at cycle 5 of a div -> all outputs 0 immediately; after release, a new mult completes normally.

Source files
------------

// File: rtl/mdu_sequencer_if.sv
// Handshake and result bus between the EX stage and the multiply/divide unit.
// The pipeline side uses the master modport; the MDU uses the slave modport.
interface mdu_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, funct, rs_val, rt_val, flush,
        input  busy, stall, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, funct, rs_val, rt_val, flush,
        output busy, stall, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit owning HI/LO.
// Multiplies with a one-bit-per-cycle shift-add loop and divides with a one-bit-per-cycle
// restoring loop, both on unsigned magnitudes. A final FIX cycle applies result signs and
// writes HI/LO, then DONE pulses for one cycle.
module mdu_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    mdu_sequencer_if.slave  bus
);

    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;
    localparam logic [5:0] FnMfhi  = 6'b010000;
    localparam logic [5:0] FnMflo  = 6'b010010;

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    // Multiply: upper half is the running partial sum, lower half the multiplier being
    // shifted out; after WIDTH steps it holds the full product magnitude.
    logic [2*WIDTH-1:0] prod_q;
    // Multiplicand magnitude for mult, divisor magnitude for div.
    logic [WIDTH-1:0]   opnd_q;
    // Dividend shifted out of the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   rem_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               is_div_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Instruction decode and operand conditioning.
    logic             is_mul_op;
    logic             is_div_op;
    logic             is_mdu_op;
    logic             is_mf_op;
    logic             is_signed_op;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic             idle_like;
    logic             accept;
    logic             busy;

    // Decode the funct field and take operand magnitudes for the signed forms.
    always_comb begin
        is_mul_op    = (bus.funct == FnMult) || (bus.funct == FnMultu);
        is_div_op    = (bus.funct == FnDiv)  || (bus.funct == FnDivu);
        is_mdu_op    = is_mul_op || is_div_op;
        is_mf_op     = (bus.funct == FnMfhi) || (bus.funct == FnMflo);
        is_signed_op = (bus.funct == FnMult) || (bus.funct == FnDiv);
        rs_neg       = is_signed_op && bus.rs_val[WIDTH-1];
        rt_neg       = is_signed_op && bus.rt_val[WIDTH-1];
        // Negating the most negative value yields 2^(WIDTH-1), which is the correct magnitude.
        rs_mag       = rs_neg ? -bus.rs_val : bus.rs_val;
        rt_mag       = rt_neg ? -bus.rt_val : bus.rt_val;
        idle_like    = (state_q == StIdle) || (state_q == StDone);
        accept       = idle_like && bus.start && is_mdu_op && !bus.flush;
        busy         = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
    end

    // Datapath step values for one multiply or divide iteration.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_fits;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quot_next;

    // Shift-add: add the multiplicand into the upper half when the current multiplier bit is
    // set, then shift the whole product register right by one with the carry entering the top.
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opnd_q : '0)};
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};
    end

    // Restoring step: bring in the next dividend bit, try subtracting the divisor and keep the
    // difference only when it did not go negative. The partial remainder never exceeds
    // 2*divisor-1, so bit WIDTH of the difference is a reliable borrow flag.
    always_comb begin
        div_shift = {rem_q, quot_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_fits  = !div_diff[WIDTH];
        rem_next  = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quot_next = {quot_q[WIDTH-2:0], div_fits};
    end

    // Sign fix-up applied in the FIX cycle.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Negate results according to the signs recorded at acceptance.
    always_comb begin
        prod_fix = neg_res_q ? -prod_q : prod_q;
        quot_fix = neg_res_q ? -quot_q : quot_q;
        rem_fix  = neg_rem_q ? -rem_q  : rem_q;
    end

    // Sequencer FSM with datapath registers and registered done/div_by_zero pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            prod_q    <= '0;
            opnd_q    <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        cnt_q     <= '0;
                        neg_res_q <= rs_neg ^ rt_neg;
                        neg_rem_q <= rs_neg;
                        is_div_q  <= is_div_op;
                        if (is_div_op) begin
                            opnd_q <= rt_mag;
                            quot_q <= rs_mag;
                            rem_q  <= '0;
                            if (bus.rt_val == '0) begin
                                // Nothing to iterate; report the fault and leave HI/LO alone.
                                state_q <= StDone;
                                done_q  <= 1'b1;
                                dbz_q   <= 1'b1;
                            end else begin
                                state_q <= StDiv;
                            end
                        end else begin
                            opnd_q  <= rs_mag;
                            prod_q  <= {{WIDTH{1'b0}}, rt_mag};
                            state_q <= StMul;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StMul: begin
                    if (bus.flush) begin
                        state_q <= StIdle;
                    end else begin
                        prod_q <= mul_next;
                        cnt_q  <= cnt_q + CntW'(1);
                        if (cnt_q == CntLast) begin
                            state_q <= StFix;
                        end
                    end
                end
                StDiv: begin
                    if (bus.flush) begin
                        state_q <= StIdle;
                    end else begin
                        rem_q  <= rem_next;
                        quot_q <= quot_next;
                        cnt_q  <= cnt_q + CntW'(1);
                        if (cnt_q == CntLast) begin
                            state_q <= StFix;
                        end
                    end
                end
                StFix: begin
                    if (bus.flush) begin
                        state_q <= StIdle;
                    end else begin
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output drive; stall only matters while an operation is actually in flight.
    always_comb begin
        bus.busy        = busy;
        bus.stall       = busy && bus.start && (is_mdu_op || is_mf_op);
        bus.done        = done_q;
        bus.div_by_zero = dbz_q;
        bus.hi          = hi_q;
        bus.lo          = lo_q;
    end

endmodule
